pbqm: RTL and testbench

- Parametrised multi-bank queue manager: N_BANKS independent queues, each with its own front/back photocell pair and teller count.
- Per bank it tracks the person count, flags full/empty, raises sticky overflow/underflow errors, and computes an estimated waiting time.
- Sits between the photocell front-end and the display/controller logic.
- Wait time uses one shared, time-multiplexed sequential divider in place of a per-bank lookup.

---
 rtl/bqm_pkg.sv | 19 +
 rtl/bqm_divider.sv | 55 +++++
 rtl/pbqm.sv | 185 ++++++++++++++++++
 tb/tb_pbqm.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bqm_pkg.sv
// Shared scheduler state, width helpers and special wait-time fill values for the bank queue manager.
// Pure declarations; no latency or backpressure.
package bqm_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, DIV, STORE} sched_t;

   // Fill bits replicated across the wait-time width
   localparam logic WT_ZERO      = 1'b0;
   localparam logic WT_NO_TELLER = 1'b1;

   function automatic int calc_cw(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int calc_nw(input int cw, input int tw, input int svc);
      return cw + tw + $clog2(svc + 1);
   endfunction

endpackage

// File: rtl/bqm_divider.sv
// Sequential restoring divider: one quotient bit per cycle, done pulses NW cycles after start.
// No backpressure; the quotient is held until the next start.
module bqm_divider #(
   parameter int NW = 7,
   parameter int DW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [NW-1:0] num,
   input  logic [DW-1:0] den,
   output logic [NW-1:0] quot,
   output logic          done
);

   localparam int              CNTW  = $clog2(NW + 1);
   localparam logic [CNTW-1:0] STEPS = CNTW'(NW);
   localparam logic [CNTW-1:0] ONE   = CNTW'(1);

   logic [NW-1:0]   dvd;
   logic [DW-1:0]   rem;
   logic [DW-1:0]   dreg;
   logic [CNTW-1:0] cnt;
   logic [DW:0]     rem_sh;
   logic            take;

   // Dividend bits shift out the top while quotient bits shift in at the bottom
   assign rem_sh = {rem, dvd[NW-1]};
   assign take   = rem_sh >= {1'b0, dreg};
   assign quot   = dvd;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dvd  <= '0;
         rem  <= '0;
         dreg <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else if (start) begin
         dvd  <= num;
         rem  <= '0;
         dreg <= den;
         cnt  <= STEPS;
         done <= 1'b0;
      end else if (cnt != '0) begin
         dvd  <= {dvd[NW-2:0], take};
         rem  <= take ? rem_sh[DW-1:0] - dreg : rem_sh[DW-1:0];
         cnt  <= cnt - ONE;
         done <= (cnt == ONE);
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/pbqm.sv
// Multi-bank queue manager: photocell events to person counts, flags and a round-robin wait-time estimate.
// Count update 2 cycles after a sampled falling edge; wait time refreshed every N_BANKS*(NW+2) cycles; no backpressure.
module pbqm
   import bqm_pkg::*;
#(
   parameter int  N_BANKS  = 4,
   parameter int  DEPTH    = 7,
   parameter int  TW       = 2,
   parameter int  WW       = 5,
   parameter int  SVC_TIME = 3,
   localparam int CW       = calc_cw(DEPTH),
   localparam int NW       = calc_nw(CW, TW, SVC_TIME)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_BANKS-1:0]    frontPC,
   input  logic [N_BANKS-1:0]    backPC,
   input  logic [N_BANKS*TW-1:0] Tcount,
   output logic [N_BANKS*CW-1:0] Pcount,
   output logic [N_BANKS*WW-1:0] Wtime,
   output logic [N_BANKS-1:0]    full,
   output logic [N_BANKS-1:0]    empty,
   output logic [N_BANKS-1:0]    ovf_err,
   output logic [N_BANKS-1:0]    udf_err
);

   localparam int              IW       = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
   localparam int              DCW      = $clog2(NW + 1);
   localparam int              QW       = NW + WW;
   localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
   localparam logic [NW-1:0]   SVC_N    = NW'(SVC_TIME);
   localparam logic [NW-1:0]   ONE_N    = NW'(1);
   localparam logic [QW-1:0]   WMAX     = QW'((1 << WW) - 1);
   localparam logic [IW-1:0]   LAST_IDX = IW'(N_BANKS - 1);
   localparam logic [DCW-1:0]  LAST_DIV = DCW'(NW - 1);

   logic [N_BANKS-1:0] f_s1, f_s2, f_prev, b_s1, b_s2, b_prev;
   logic [N_BANKS-1:0] ev_dn, ev_up;
   logic [CW-1:0]      pcnt [N_BANKS];
   logic [WW-1:0]      wt   [N_BANKS];

   // Synchronisers idle high so reset never fabricates a falling edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         f_s1   <= '1;
         f_s2   <= '1;
         f_prev <= '1;
         b_s1   <= '1;
         b_s2   <= '1;
         b_prev <= '1;
      end else begin
         f_s1   <= frontPC;
         f_s2   <= f_s1;
         f_prev <= f_s2;
         b_s1   <= backPC;
         b_s2   <= b_s1;
         b_prev <= b_s2;
      end
   end

   assign ev_dn = f_prev & ~f_s2;
   assign ev_up = b_prev & ~b_s2;

   for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
      logic [CW-1:0] cnt_q, cnt_d;
      logic          at_max, at_min, full_q, empty_q, ovf_q, udf_q;

      assign at_max = (cnt_q == DEPTH_C);
      assign at_min = (cnt_q == '0);

      always_comb begin
         cnt_d = cnt_q;
         if (ev_up[b] && !ev_dn[b] && !at_max)
            cnt_d = cnt_q + CW'(1);
         else if (ev_dn[b] && !ev_up[b] && !at_min)
            cnt_d = cnt_q - CW'(1);
      end

      // Flags come from the next count so they move in the same cycle as Pcount
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == DEPTH_C);
            empty_q <= (cnt_d == '0);
            if (ev_up[b] && !ev_dn[b] && at_max) ovf_q <= 1'b1;
            if (ev_dn[b] && !ev_up[b] && at_min) udf_q <= 1'b1;
         end
      end

      assign pcnt[b]              = cnt_q;
      assign Pcount[b*CW +: CW]   = cnt_q;
      assign Wtime[b*WW +: WW]    = wt[b];
      assign full[b]              = full_q;
      assign empty[b]             = empty_q;
      assign ovf_err[b]           = ovf_q;
      assign udf_err[b]           = udf_q;
   end

   sched_t         state, state_nxt;
   logic [IW-1:0]  idx;
   logic [DCW-1:0] dcnt;
   logic [CW-1:0]  p_cur, p_snap;
   logic [TW-1:0]  t_cur, t_snap;
   logic [NW-1:0]  num, quot;
   logic [QW-1:0]  q_ext;
   logic [WW-1:0]  w_val;
   logic           div_start, div_done;

   assign p_cur = pcnt[idx];
   assign t_cur = Tcount[idx*TW +: TW];
   assign num   = SVC_N * (NW'(p_cur) + NW'(t_cur) - ONE_N);
   assign q_ext = QW'(quot);

   bqm_divider #(.NW(NW), .DW(TW)) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (div_start),
      .num   (num),
      .den   (t_cur),
      .quot  (quot),
      .done  (div_done)
   );

   always_comb begin
      state_nxt = state;
      div_start = 1'b0;
      case (state)
         IDLE:  state_nxt = LOAD;
         LOAD: begin
            div_start = 1'b1;
            state_nxt = DIV;
         end
         DIV:   if (dcnt == LAST_DIV) state_nxt = STORE;
         STORE: state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   // Special cases use the snapshot, matching the numerator the divider saw
   always_comb begin
      w_val = q_ext[WW-1:0];
      if (p_snap == '0)
         w_val = {WW{WT_ZERO}};
      else if (t_snap == '0)
         w_val = {WW{WT_NO_TELLER}};
      else if (q_ext > WMAX)
         w_val = '1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx    <= '0;
         dcnt   <= '0;
         p_snap <= '0;
         t_snap <= '0;
         for (int i = 0; i < N_BANKS; i++) wt[i] <= '0;
      end else begin
         case (state)
            LOAD: begin
               p_snap <= p_cur;
               t_snap <= t_cur;
               dcnt   <= '0;
            end
            DIV: dcnt <= dcnt + DCW'(1);
            STORE: begin
               if (div_done) wt[idx] <= w_val;
               idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pbqm.sv
// Directed and randomised checks of pbqm against a per-bank count and wait-time reference model.
module tb_pbqm;

   localparam int NB = 4, DEPTH = 7, TW = 2, WW = 5, SVC = 3, CW = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NB-1:0]    frontPC = '1;
   logic [NB-1:0]    backPC  = '1;
   logic [NB*TW-1:0] Tcount  = '0;
   logic [NB*CW-1:0] Pcount;
   logic [NB*WW-1:0] Wtime;
   logic [NB-1:0]    full, empty, ovf_err, udf_err;

   int tests = 0;
   int fails = 0;
   int mp [NB];
   int mt [NB];
   bit mo [NB];
   bit mu [NB];

   pbqm #(.N_BANKS(NB), .DEPTH(DEPTH), .TW(TW), .WW(WW), .SVC_TIME(SVC)) dut (
      .clk     (clk),
      .rst     (rst),
      .frontPC (frontPC),
      .backPC  (backPC),
      .Tcount  (Tcount),
      .Pcount  (Pcount),
      .Wtime   (Wtime),
      .full    (full),
      .empty   (empty),
      .ovf_err (ovf_err),
      .udf_err (udf_err)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int wt_model(input int p, input int t);
      int q;
      if (p == 0) return 0;
      if (t == 0) return (1 << WW) - 1;
      q = (SVC * (p + t - 1)) / t;
      return (q > (1 << WW) - 1) ? (1 << WW) - 1 : q;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NB; b++) begin
         mp[b] = 0;
         mo[b] = 1'b0;
         mu[b] = 1'b0;
      end
   endtask

   task automatic set_t(input int b, input int v);
      Tcount[b*TW +: TW] = TW'(v);
      mt[b] = v;
   endtask

   task automatic apply(input logic [NB-1:0] fm, input logic [NB-1:0] bm);
      for (int b = 0; b < NB; b++) begin
         if (bm[b] && !fm[b]) begin
            if (mp[b] < DEPTH) mp[b]++; else mo[b] = 1'b1;
         end else if (fm[b] && !bm[b]) begin
            if (mp[b] > 0) mp[b]--; else mu[b] = 1'b1;
         end
      end
   endtask

   // One-cycle low pulse on the selected photocells, then settle
   task automatic pulse(input logic [NB-1:0] fm, input logic [NB-1:0] bm);
      frontPC = ~fm;
      backPC  = ~bm;
      tick();
      frontPC = '1;
      backPC  = '1;
      tick(3);
      apply(fm, bm);
   endtask

   task automatic check_cnt();
      for (int b = 0; b < NB; b++) begin
         chk($sformatf("pcount[%0d]", b), 32'(Pcount[b*CW +: CW]), 32'(mp[b]));
         chk($sformatf("full[%0d]", b),   32'(full[b]),    32'(mp[b] == DEPTH));
         chk($sformatf("empty[%0d]", b),  32'(empty[b]),   32'(mp[b] == 0));
         chk($sformatf("ovf[%0d]", b),    32'(ovf_err[b]), 32'(mo[b]));
         chk($sformatf("udf[%0d]", b),    32'(udf_err[b]), 32'(mu[b]));
      end
   endtask

   task automatic check_wt();
      for (int b = 0; b < NB; b++)
         chk($sformatf("wtime[%0d]", b), 32'(Wtime[b*WW +: WW]), 32'(wt_model(mp[b], mt[b])));
   endtask

   initial begin
      logic [NB-1:0] fm, bm;

      for (int b = 0; b < NB; b++) set_t(b, 1);
      model_reset();
      tick(2);
      check_cnt();
      check_wt();
      rst = 1'b1;
      tick(2);

      // Fill bank 0 past DEPTH, then drain past zero
      repeat (8) pulse('0, 4'b0001);
      check_cnt();
      repeat (8) pulse(4'b0001, '0);
      check_cnt();

      // Simultaneous enter/leave at both count limits
      pulse(4'b0010, 4'b0010);
      check_cnt();
      repeat (7) pulse('0, 4'b0010);
      check_cnt();
      pulse(4'b0010, 4'b0010);
      check_cnt();

      // Wait-time cases on bank 2
      set_t(2, 2);
      repeat (5) pulse('0, 4'b0100);
      tick(72);
      check_wt();
      set_t(2, 0);
      tick(72);
      check_wt();
      set_t(2, 3);
      repeat (2) pulse('0, 4'b0100);
      tick(72);
      check_wt();
      check_cnt();

      // Exact synchroniser latency and single event for a held-low input
      backPC[3] = 1'b0;
      tick();
      chk("lat_k",   32'(Pcount[3*CW +: CW]), 32'(mp[3]));
      tick();
      chk("lat_k+1", 32'(Pcount[3*CW +: CW]), 32'(mp[3]));
      tick();
      chk("lat_k+2", 32'(Pcount[3*CW +: CW]), 32'(mp[3] + 1));
      apply('0, 4'b1000);
      tick(17);
      chk("held_low", 32'(Pcount[3*CW +: CW]), 32'(mp[3]));
      backPC[3] = 1'b1;
      tick(3);
      check_cnt();

      // Randomised traffic and teller counts
      for (int it = 0; it < 30; it++) begin
         fm = NB'($urandom_range(0, (1 << NB) - 1));
         bm = NB'($urandom_range(0, (1 << NB) - 1));
         pulse(fm, bm);
         check_cnt();
         if (it % 10 == 9) begin
            for (int b = 0; b < NB; b++) set_t(b, $urandom_range(0, (1 << TW) - 1));
            tick(72);
            check_wt();
         end
      end

      // Scheduler slot timing from reset release, then reset during bank 1 DIV
      rst = 1'b0;
      backPC = 4'b1100;
      frontPC = '1;
      for (int b = 0; b < NB; b++) set_t(b, 1);
      model_reset();
      #1;
      check_cnt();
      check_wt();
      tick();
      rst = 1'b1;
      tick(18);
      chk("wt1_pre_store", 32'(Wtime[1*WW +: WW]), 32'(0));
      tick();
      chk("wt1_store", 32'(Wtime[1*WW +: WW]), 32'(wt_model(1, 1)));
      mp[0] = 1;
      mp[1] = 1;
      check_cnt();
      tick(26);
      chk("wt0_pre_store", 32'(Wtime[0*WW +: WW]), 32'(0));
      tick();
      chk("wt0_store", 32'(Wtime[0*WW +: WW]), 32'(wt_model(1, 1)));
      tick(3);
      rst = 1'b0;
      #1;
      model_reset();
      check_cnt();
      check_wt();
      backPC = '1;
      tick();
      rst = 1'b1;
      tick(12);
      check_cnt();
      check_wt();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
